// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and sel saturation for the tick scheduler
package clkdiv_pkg;

  localparam int CW_DEF = 4;

  localparam logic [2:0] SEL_OFF = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'(CW_DEF);

  function automatic logic [2:0] sat_sel(input logic [2:0] sel, input logic [2:0] lim);
    return (sel > lim) ? lim : sel;
  endfunction

endpackage

// File: rtl/prescale_counter.sv
// rtl/prescale_counter.sv - free-running prescale counter, parked at 0 while idle
module prescale_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [CW-1:0] count,
  output logic          wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  assign wrap = run && (&count);

endmodule

// File: rtl/clkdiv_sched.sv
// rtl/clkdiv_sched.sv - per-requester divide settings committed at counter wrap, tick decode
module clkdiv_sched
  import clkdiv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [$clog2(NREQ)-1:0] cfg_id,
  input  logic [2:0]              cfg_sel,
  output logic                    cfg_ready,
  output logic [NREQ-1:0]         cfg_done,
  output logic [NREQ-1:0]         tick,
  output logic [NREQ-1:0]         active,
  output logic [CW-1:0]           count
);

  localparam int         IDW     = $clog2(NREQ);
  localparam logic [2:0] SEL_LIM = 3'(CW);

  logic [2:0]        act_sel  [NREQ];
  logic [2:0]        pend_sel [NREQ];
  logic [NREQ-1:0]   pend_vld;
  logic [2**IDW-1:0] pend_vld_ext;
  logic              run;
  logic              wrap;
  logic              commit;
  logic              accept;

  prescale_counter #(.CW(CW)) u_prescale (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .count (count),
    .wrap  (wrap)
  );

  // Ids beyond NREQ (non power-of-two NREQ) read as permanently busy and are never accepted.
  always_comb begin
    pend_vld_ext            = '1;
    pend_vld_ext[NREQ-1:0]  = pend_vld;
  end

  assign cfg_ready = !pend_vld_ext[cfg_id];
  assign accept    = cfg_valid && cfg_ready;
  assign run       = |active;
  assign commit    = wrap || !run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= '0;
      cfg_done <= '0;
      for (int i = 0; i < NREQ; i++) begin
        act_sel[i]  <= SEL_OFF;
        pend_sel[i] <= SEL_OFF;
      end
    end else begin
      cfg_done <= commit ? pend_vld : '0;
      for (int i = 0; i < NREQ; i++) begin
        if (commit && pend_vld[i]) begin
          act_sel[i]  <= pend_sel[i];
          pend_vld[i] <= 1'b0;
        end
        // A committing id was pending, so it cannot also be accepted this cycle.
        if (accept && cfg_id == IDW'(i)) begin
          pend_sel[i] <= sat_sel(cfg_sel, SEL_LIM);
          pend_vld[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [CW-1:0] mask;
    active = '0;
    tick   = '0;
    mask   = '0;
    for (int i = 0; i < NREQ; i++) begin
      active[i] = (act_sel[i] != SEL_OFF);
      mask      = CW'((32'd1 << act_sel[i]) - 32'd1);
      tick[i]   = active[i] && ((count & mask) == mask);
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb/tb_clkdiv_sched.sv - directed scenarios plus random traffic against an arithmetic reference model
module tb_clkdiv_sched;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int PER  = 1 << CW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic [1:0]      cfg_id = '0;
  logic [2:0]      cfg_sel = '0;
  logic            cfg_ready;
  logic [NREQ-1:0] cfg_done;
  logic [NREQ-1:0] tick;
  logic [NREQ-1:0] active;
  logic [CW-1:0]   count;

  int tests = 0;
  int fails = 0;

  int              m_act  [NREQ];
  int              m_pend [NREQ];
  bit              m_pvld [NREQ];
  int              m_cnt;
  logic [NREQ-1:0] m_done;

  clkdiv_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_id    (cfg_id),
    .cfg_sel   (cfg_sel),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .tick      (tick),
    .active    (active),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_run();
    for (int i = 0; i < NREQ; i++) if (m_act[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_pvld[i] = 1'b0;
    end
    m_cnt  = 0;
    m_done = '0;
  endtask

  task automatic model_edge();
    bit run, cp, acc;
    run = m_run();
    cp  = !run || (m_cnt == PER - 1);
    acc = cfg_valid && !m_pvld[cfg_id];
    m_done = '0;
    if (cp) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_pvld[i]) begin
          m_act[i] = m_pend[i]; m_pvld[i] = 1'b0; m_done[i] = 1'b1;
        end
      end
    end
    if (acc) begin
      m_pend[cfg_id] = (int'(cfg_sel) > CW) ? CW : int'(cfg_sel);
      m_pvld[cfg_id] = 1'b1;
    end
    m_cnt = run ? (m_cnt + 1) % PER : 0;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] etick, eact;
    for (int i = 0; i < NREQ; i++) begin
      eact[i]  = (m_act[i] != 0);
      etick[i] = (m_act[i] != 0) && (((m_cnt + 1) % (1 << m_act[i])) == 0);
    end
    check("count", 32'(count), 32'(m_cnt));
    check("tick", 32'(tick), 32'(etick));
    check("active", 32'(active), 32'(eact));
    check("cfg_done", 32'(cfg_done), 32'(m_done));
  endtask

  // Called at posedge+1; checks ready with current inputs, advances one clock, checks registered outputs.
  task automatic step();
    #1;
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pvld[cfg_id]));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic req(input int id, input int sel);
    bit done = 1'b0;
    cfg_valid = 1'b1;
    cfg_id    = 2'(id);
    cfg_sel   = 3'(sel);
    for (int k = 0; k < 3 * PER && !done; k++) begin
      done = !m_pvld[id];
      step();
    end
    if (!done) check("req_timeout", 32'd0, 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_count(input int c);
    int k = 0;
    cfg_valid = 1'b0;
    while (m_cnt != c && k < 2 * PER) begin
      step();
      k++;
    end
    if (m_cnt != c) check("count_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    cfg_valid = 1'b0;
    model_reset();
    #1;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    check("reset_done", 32'(cfg_done), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;

    req(0, 1);
    idle(8);
    check("sel1_running", 32'(active), 32'b0001);

    wait_count(5);
    req(1, 4);
    idle(40);

    cfg_valid = 1'b1; cfg_id = 2'd2; cfg_sel = 3'd2;
    step();
    cfg_sel = 3'd3;
    req(2, 3);
    idle(30);

    req(3, 7);
    idle(36);

    req(1, 0); req(2, 0); req(3, 0);
    idle(20);
    req(0, 0);
    idle(PER + 4);
    check("all_off_active", 32'(active), 32'd0);
    idle(40);
    check("quiet_count", 32'(count), 32'd0);

    req(0, 2);
    idle(5);
    req(1, 3);
    idle(3);
    check("pending_before_rst", 32'(m_pvld[1]), 32'd1);
    do_reset();
    idle(20);
    check("idle_after_rst", 32'(count), 32'd0);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_valid = 1'b1;
        cfg_id    = 2'($urandom_range(0, NREQ - 1));
        cfg_sel   = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      end else begin
        cfg_valid = 1'b0;
      end
      step();
      if (k == 700) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
